// File: rtl/nf5_mem_arb_pkg.sv
// Shared types and constants for the nf5 memory port arbiter.
package nf5_mem_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
  typedef enum logic {SRC_IF = 1'b0, SRC_D = 1'b1} grant_src_e;

  localparam int         MEM_LAT_MAX = 4;
  localparam logic [3:0] BE_FULL     = 4'hF;

endpackage

// File: rtl/nf5_mem_arb_resp_track.sv
// Tracks in-flight accesses through the fixed memory latency, captures read
// data and raises the one-cycle response pulse on the port that issued it.
module nf5_mem_arb_resp_track
  import nf5_mem_arb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  grant_src_e        issue_src,
  input  logic              issue_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data
);

  logic cur_vld;
  logic cur_src_d;
  logic cur_we;

  // The access whose read data is on mem_rdata this cycle is either the one
  // being issued now (single-cycle memory) or the oldest pipeline entry.
  if (MEM_LAT == 1) begin : g_lat1
    assign cur_vld   = issue;
    assign cur_src_d = (issue_src == SRC_D);
    assign cur_we    = issue_we;
  end else begin : g_sr
    logic [MEM_LAT-2:0] vld_sr;
    logic [MEM_LAT-2:0] src_sr;
    logic [MEM_LAT-2:0] we_sr;

    // Latency shift register: valid, source tag and store flag per access.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_sr <= '0;
        src_sr <= '0;
        we_sr  <= '0;
      end else begin
        vld_sr[0] <= issue;
        src_sr[0] <= (issue_src == SRC_D);
        we_sr[0]  <= issue_we;
        for (int i = 1; i < MEM_LAT - 1; i++) begin
          vld_sr[i] <= vld_sr[i-1];
          src_sr[i] <= src_sr[i-1];
          we_sr[i]  <= we_sr[i-1];
        end
      end
    end

    assign cur_vld   = vld_sr[MEM_LAT-2];
    assign cur_src_d = src_sr[MEM_LAT-2];
    assign cur_we    = we_sr[MEM_LAT-2];
  end

  // Response pulse and data capture; stores acknowledge with zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_resp_valid <= 1'b0;
      if_resp_data  <= {DATA_W{1'b0}};
      d_resp_valid  <= 1'b0;
      d_resp_data   <= {DATA_W{1'b0}};
    end else begin
      if_resp_valid <= cur_vld && !cur_src_d;
      d_resp_valid  <= cur_vld && cur_src_d;
      if (cur_vld && !cur_src_d) begin
        if_resp_data <= mem_rdata;
      end
      if (cur_vld && cur_src_d) begin
        d_resp_data <= cur_we ? {DATA_W{1'b0}} : mem_rdata;
      end
    end
  end

endmodule

// File: rtl/nf5_mem_port_arbiter.sv
// Arbitrates the fetch and load/store ports onto one fixed-latency memory.
// Define NF5_MEM_ARB_PERF_EN to add grant/conflict performance counters.
module nf5_mem_port_arbiter
  import nf5_mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [3:0]        d_req_be,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef NF5_MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_conflicts
`endif
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
  localparam logic [1:0] LAT_INIT   = 2'(MEM_LAT - 1);

  state_e     state;
  logic [1:0] lat_cnt;
  logic [7:0] starve_cnt;
  logic       can_issue;
  logic       grant_d;
  logic       grant_if;
  logic       issue;
  logic       unused_lsbs;

  assign unused_lsbs = ^{if_req_addr[1:0], d_req_addr[1:0]};

  // Data has priority until fetch has waited STARVE_MAX data grants.
  assign can_issue    = (state == IDLE) && !rst;
  assign grant_d      = can_issue && d_req_valid &&
                        (!if_req_valid || (starve_cnt != STARVE_LIM));
  assign grant_if     = can_issue && if_req_valid && !grant_d;
  assign issue        = grant_d || grant_if;
  assign if_req_ready = grant_if;
  assign d_req_ready  = grant_d;

  // Memory strobe and command are driven straight from the winner.
  always_comb begin
    mem_en    = issue;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = {(ADDR_W-2){1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (grant_d) begin
      mem_we    = d_req_we;
      mem_be    = d_req_be;
      mem_addr  = d_req_addr[ADDR_W-1:2];
      mem_wdata = d_req_wdata;
    end else if (grant_if) begin
      mem_be    = BE_FULL;
      mem_addr  = if_req_addr[ADDR_W-1:2];
    end else begin
      mem_en    = 1'b0;
    end
  end

  // Occupancy FSM: BUSY covers the cycles between issue and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (issue && (MEM_LAT > 1)) begin
            state   <= BUSY;
            lat_cnt <= LAT_INIT;
          end
        end
        BUSY: begin
          if (lat_cnt == 2'd1) begin
            state <= IDLE;
          end
          lat_cnt <= lat_cnt - 2'd1;
        end
        default: begin
          state   <= IDLE;
          lat_cnt <= 2'd0;
        end
      endcase
    end
  end

  // Starvation counter: data grants taken while fetch is waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 8'd0;
    end else if (!if_req_valid || grant_if) begin
      starve_cnt <= 8'd0;
    end else if (grant_d && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  nf5_mem_arb_resp_track #(
    .DATA_W  (DATA_W),
    .MEM_LAT (MEM_LAT)
  ) u_resp_track (
    .clk           (clk),
    .rst           (rst),
    .issue         (issue),
    .issue_src     (grant_d ? SRC_D : SRC_IF),
    .issue_we      (grant_d && d_req_we),
    .mem_rdata     (mem_rdata),
    .if_resp_valid (if_resp_valid),
    .if_resp_data  (if_resp_data),
    .d_resp_valid  (d_resp_valid),
    .d_resp_data   (d_resp_data)
  );

`ifdef NF5_MEM_ARB_PERF_EN
  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_grants <= 32'd0;
      perf_d_grants  <= 32'd0;
      perf_conflicts <= 32'd0;
    end else begin
      if (grant_if) begin
        perf_if_grants <= perf_if_grants + 32'd1;
      end
      if (grant_d) begin
        perf_d_grants <= perf_d_grants + 32'd1;
      end
      if (if_req_valid && d_req_valid) begin
        perf_conflicts <= perf_conflicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/nf5_mem_port_arbiter.md
Name: nf5_mem_port_arbiter

Overview:
Shares one single-ported, fixed-latency memory (the core's unified instruction/data array) between two requesters: the IF-stage fetch port and the MEM-stage load/store port.
- Sits between the Core pipeline and the memory array.
- Sequences one transaction at a time.
- Gives the data port priority, with a starvation bound so fetch always progresses.

Parameters:
- ADDR_W, 32, byte-address width of both requesters.
- DATA_W, 32, data width. Fixed at 32; byte enables are DATA_W/8.
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata. Legal range 1..4.
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req_valid  in  1  fetch request.
- if_req_addr  in  ADDR_W  fetch byte address, word-aligned.
- if_req_ready  out  1  fetch accepted this cycle.
- if_resp_valid  out  1  fetch data valid, one-cycle pulse.
- if_resp_data  out  DATA_W  instruction word.
- d_req_valid  in  1  data request.
- d_req_we  in  1  1 = store, 0 = load.
- d_req_be  in  4  store byte enables.
- d_req_addr  in  ADDR_W  data byte address.
- d_req_wdata  in  DATA_W  store data.
- d_req_ready  out  1  data accepted this cycle.
- d_resp_valid  out  1  load data or store ack, one-cycle pulse.
- d_resp_data  out  DATA_W  load data; 0 for stores.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_be  out  4  memory byte enables.
- mem_addr  out  ADDR_W-2  word index, taken from req_addr[ADDR_W-1:2].
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset values: all outputs 0; state IDLE; starve_cnt 0; any in-flight response is dropped. Reset mid-transaction gives no resp pulse after release.
- Handshake: a request is accepted in a cycle where valid and ready are both high. The requester holds valid, addr, we, be and wdata stable until accepted. At most one ready is high per cycle.
- Issue: in the accept cycle, mem_en=1 and mem_* are driven combinationally from the winner.
  - Fetch issue: we=0, be=4'hF.
  - mem_en is 0 in every other cycle.
- Response: for an issue in cycle T, the selected resp_valid is high in cycle T+MEM_LAT only, with resp_data = mem_rdata registered at the end of cycle T+MEM_LAT-1. A store gives an ack pulse with data 0.
- Occupancy: ready may be high in cycle C only if no issue happened in cycles C-MEM_LAT+1 .. C-1.
  - A new issue may coincide with the previous response cycle, so MEM_LAT=1 sustains one transaction per cycle.
- FSM:
  - IDLE: no request outstanding.
  - BUSY: lat_cnt counts down MEM_LAT-1 .. 1, then returns to IDLE.
  - An issue from IDLE with MEM_LAT=1 stays in IDLE.
- Arbitration, applied when both requests are valid:
  - Data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - starve_cnt increments (saturating) on a data grant while if_req_valid=1.
  - starve_cnt clears on a fetch grant, or in any cycle with if_req_valid=0.
  - A lone requester wins immediately.
- Resp routing: a grant-source flag is registered at issue and tagged to that response; it is never re-arbitrated.
- Misaligned addresses: low two bits are ignored, with no error.

Optional Feature:
- Macro: NF5_MEM_ARB_PERF_EN.
- When defined, three 32-bit outputs are added: perf_if_grants, perf_d_grants and perf_conflicts (cycles with both valid).
  - Each increments by 1 per event and wraps at 2^32.
  - Reset to 0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package nf5_mem_arb_pkg holds:
  - state enum {IDLE, BUSY};
  - grant-source enum {SRC_IF, SRC_D};
  - MEM_LAT_MAX=4;
  - BE_FULL=4'hF.
- One sub-module, nf5_mem_arb_resp_track: latency shift register carrying valid and the source tag, plus rdata capture and resp pulse generation.
- Arbitration and the FSM stay in the top level.

Test Plan:
- Reset: rst high for 3 cycles while both valid=1 -> all outputs 0, no mem_en. The first grant after release goes to data.
- Lone fetch, MEM_LAT=1, addr 0x2F4: mem_addr=0xBD in the issue cycle; the following cycle gives if_resp_valid=1 with data = the word stored at 0xBD.
- Contention, STARVE_MAX=4, both valid continuously for 10 cycles -> grant order D,D,D,D,IF,D,D,D,D,IF.
- Store, be=4'b0011, wdata 0xDEADBEEF to 0x100, then a load from 0x100 -> d_resp_data shows the low 16 bits 0xBEEF merged with the prior upper half. The store ack data is 0.
- MEM_LAT=3, back-to-back fetches -> issues at cycles 0, 3, 6 and if_resp_valid at 3, 6, 9. Ready is low in cycles 1-2 and 4-5.
- rst asserted in the cycle after a data issue with MEM_LAT=3 -> no d_resp_valid ever appears for that request.
